// File: rtl/mux_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// Holds the FSM state encoding and the index-to-select mapping.
package mux_pkg;
   localparam int SEL_W  = 2;
   localparam int NUM_IN = 4;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   typedef logic [SEL_W-1:0] sel_t;

   // Mux index = 2*s1 + s0, so the select pair is just the index bits.
   function automatic logic [1:0] sel_to_s(input sel_t idx);
      return {idx[1], idx[0]};
   endfunction
endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Select/capture bus between the scan sequencer and the gate-level 4:1 mux.
// The master side drives the selects and reports the captured word.
interface mux_scan_sequencer_if;
   import mux_pkg::*;

   logic              start;
   logic              w;
   logic              s0;
   logic              s1;
   logic              busy;
   logic              done;
   logic [NUM_IN-1:0] data;

   modport master (input start, input w,
                   output s0, output s1, output busy, output done, output data);
   modport slave  (output start, output w,
                   input s0, input s1, input busy, input done, input data);
endinterface

// File: rtl/dwell_counter.sv
// Per-select dwell timer: counts 0..DWELL-1 while enabled and flags the last cycle.
// Wraps to zero on its terminal count so back-to-back dwells need no extra clear.
module dwell_counter #(
   parameter int DWELL = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);
   localparam int            CW   = $clog2(DWELL + 1);
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= o_tc ? '0 : r_cnt + CW'(1);
   end

   assign o_tc = (r_cnt == LAST);
endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the mux select through indices 0..3, samples w after each dwell,
// and publishes the four captured bits with a one-cycle done pulse.
module mux_scan_sequencer
   import mux_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   mux_scan_sequencer_if.master io_mux
);
   state_t            r_state;
   sel_t              r_sel;
   logic [NUM_IN-1:0] r_shadow;
   logic [NUM_IN-1:0] r_data;
   logic              r_s0;
   logic              r_s1;
   logic              r_busy;
   logic              r_done;

   logic              w_tc;
   logic              w_cnt_en;
   logic              w_cnt_clr;
   sel_t              w_sel_nxt;
   logic [NUM_IN-1:0] w_shadow_nxt;

   assign w_cnt_en  = (r_state == SCAN);
   assign w_cnt_clr = (r_state != SCAN);
   assign w_sel_nxt = r_sel + sel_t'(1);

   dwell_counter #(.DWELL(DWELL)) u_dwell (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_cnt_clr),
      .i_en  (w_cnt_en),
      .o_tc  (w_tc)
   );

   // Shadow with the current index's bit replaced by w; on the last capture
   // this is the complete word, so data can load it on the same edge.
   always_comb begin
      w_shadow_nxt        = r_shadow;
      w_shadow_nxt[r_sel] = io_mux.w;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_sel    <= '0;
         r_shadow <= '0;
         r_data   <= '0;
         r_s0     <= 1'b0;
         r_s1     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (io_mux.start) begin
                  r_state      <= SCAN;
                  r_sel        <= '0;
                  r_shadow     <= '0;
                  r_busy       <= 1'b1;
                  {r_s1, r_s0} <= sel_to_s('0);
               end
            end
            SCAN: begin
               if (w_tc) begin
                  r_shadow <= w_shadow_nxt;
                  if (r_sel == sel_t'(NUM_IN - 1)) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_data  <= w_shadow_nxt;
                  end else begin
                     r_sel        <= w_sel_nxt;
                     {r_s1, r_s0} <= sel_to_s(w_sel_nxt);
                  end
               end
            end
            DONE: begin
               r_state      <= IDLE;
               {r_s1, r_s0} <= sel_to_s('0);
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign io_mux.s0   = r_s0;
   assign io_mux.s1   = r_s1;
   assign io_mux.busy = r_busy;
   assign io_mux.done = r_done;
   assign io_mux.data = r_data;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a behavioural 4:1 mux closing the loop.
// Instance dut1 uses DWELL=4, dut2 uses DWELL=1 with start held high.
module tb_mux_scan_sequencer;
   logic clk = 1'b0;
   logic rst, rst2;
   logic aa, bb, cc, dd;
   int   checks = 0;
   int   errors = 0;
   int   fd, nd;

   always #5 clk = ~clk;

   mux_scan_sequencer_if if1 ();
   mux_scan_sequencer_if if2 ();

   function automatic logic pick(input logic [1:0] s);
      case (s)
         2'd0:    return aa;
         2'd1:    return bb;
         2'd2:    return cc;
         default: return dd;
      endcase
   endfunction

   assign if1.w = pick({if1.s1, if1.s0});
   assign if2.w = pick({if2.s1, if2.s0});

   mux_scan_sequencer #(.DWELL(4)) dut1 (.i_clk(clk), .i_rst(rst),  .io_mux(if1));
   mux_scan_sequencer #(.DWELL(1)) dut2 (.i_clk(clk), .i_rst(rst2), .io_mux(if2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse start, then watch ncyc cycles. Optional reset at cycle rst_at,
   // cc flip at cycle flip_at, and start pulses during the scan when pester=1.
   task automatic run(input int ncyc, input int rst_at, input int flip_at, input bit pester,
                      output int first_done, output int n_done);
      if1.start = 1'b1;
      tick();
      if1.start  = 1'b0;
      first_done = 0;
      n_done     = 0;
      for (int c = 1; c <= ncyc; c++) begin
         if (if1.done) begin
            n_done++;
            if (first_done == 0) first_done = c;
         end
         if (rst_at == 0 && c <= 16) begin
            chk("scan_sel",  {30'd0, if1.s1, if1.s0}, (c - 1) / 4);
            chk("scan_busy", {31'd0, if1.busy}, 1);
         end
         if (rst_at == 0 && c == 17) chk("done_busy", {31'd0, if1.busy}, 0);
         if (rst_at == 0 && c == 18) chk("idle_sel", {30'd0, if1.s1, if1.s0}, 0);
         if (rst_at != 0 && c == rst_at + 1) begin
            chk("rst_busy", {31'd0, if1.busy}, 0);
            chk("rst_sel",  {30'd0, if1.s1, if1.s0}, 0);
            chk("rst_data", {28'd0, if1.data}, 0);
            chk("rst_done", {31'd0, if1.done}, 0);
         end
         if1.start = pester && (c <= 17) && ((c % 4 == 3) || c == 17);
         rst       = (c == rst_at);
         if (c == flip_at) cc = ~cc;
         tick();
      end
      if1.start = 1'b0;
      rst       = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rst2 = 1'b1;
      if1.start = 1'b0; if2.start = 1'b0;
      aa = 1'b1; bb = 1'b0; cc = 1'b1; dd = 1'b0;
      tick();
      tick();
      chk("reset_busy", {31'd0, if1.busy}, 0);
      chk("reset_done", {31'd0, if1.done}, 0);
      chk("reset_data", {28'd0, if1.data}, 0);
      chk("reset_sel",  {30'd0, if1.s1, if1.s0}, 0);
      rst = 1'b0;
      tick();

      // Scan 1: aa=1 bb=0 cc=1 dd=0
      run(25, 0, 0, 1'b0, fd, nd);
      chk("lat1",   fd, 17);
      chk("ndone1", nd, 1);
      chk("data1",  {28'd0, if1.data}, 4'b0101);

      // New inputs; data must hold until the next scan completes
      aa = 1'b1; bb = 1'b0; cc = 1'b0; dd = 1'b1;
      tick();
      tick();
      chk("hold", {28'd0, if1.data}, 4'b0101);
      run(25, 0, 0, 1'b0, fd, nd);
      chk("lat2",  fd, 17);
      chk("data2", {28'd0, if1.data}, 4'b1001);

      // Reset in cycle 9 of a scan: no done, data cleared
      run(30, 9, 0, 1'b0, fd, nd);
      chk("rst_nodone", nd, 0);
      run(25, 0, 0, 1'b0, fd, nd);
      chk("lat_after_rst",  fd, 17);
      chk("data_after_rst", {28'd0, if1.data}, 4'b1001);

      // Start pulsed while busy and in DONE: ignored
      run(30, 0, 0, 1'b1, fd, nd);
      chk("pester_ndone", nd, 1);
      chk("pester_lat",   fd, 17);

      // cc flips 0->1 at cycle 2 of index 2; capture sees the new value
      run(25, 0, 10, 1'b0, fd, nd);
      chk("flip_lat",  fd, 17);
      chk("flip_data", {28'd0, if1.data}, 4'b1101);

      // DWELL=1, start held high: done every 6 cycles, first at 5
      aa = 1'b0; bb = 1'b1; cc = 1'b1; dd = 1'b0;
      rst2 = 1'b0;
      if2.start = 1'b1;
      tick();
      begin
         int         prev_c = 0;
         int         nd2 = 0;
         logic       pbusy = 1'b0;
         logic [1:0] psel = 2'd0;
         logic [1:0] sel, exp_sel;
         for (int c = 1; c <= 30; c++) begin
            sel     = {if2.s1, if2.s0};
            exp_sel = psel + 2'd1;
            if (if2.busy && pbusy)  chk("d1_sel_step",  {30'd0, sel}, {30'd0, exp_sel});
            if (if2.busy && !pbusy) chk("d1_sel_first", {30'd0, sel}, 0);
            if (if2.done) begin
               nd2++;
               chk("d1_data", {28'd0, if2.data}, 4'b0110);
               if (prev_c != 0) chk("d1_gap", c - prev_c, 6);
               else             chk("d1_lat", c, 5);
               prev_c = c;
            end
            pbusy = if2.busy;
            psel  = sel;
            tick();
         end
         chk("d1_count", nd2, 5);
      end
      if2.start = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
